// File: rtl/sine_sample_gen.sv
// -----------------------------------------------------------------------------
// sine_sample_gen
//
// Direct-digital-synthesis sample source for the sine PWM modulator. Each
// accepted request advances a phase accumulator by fcw, folds the captured
// phase through a quarter-wave sine table and returns an offset-binary sample
// with sample_valid high in the cycle after the second edge following the
// request edge.
//
// Pipeline:
//   stage 0 (request edge) : capture phase, advance accumulator, latch carry
//   stage 1                : split phase into quadrant and table index
//   stage 2                : table read, quadrant fold, output registers
//
// Ports:
//   clk_100      in   1            100 MHz system clock, rising edge
//   rst_n        in   1            asynchronous active-low reset
//   en           in   1            enable shared with the PWM modulator
//   fcw          in   PHASE_WIDTH  frequency control word, used on acceptance
//   sample_req   in   1            one-cycle request at each PWM period start
//   sample       out  DATA_WIDTH   offset-binary sine sample, holds between valids
//   sample_valid out  1            one-cycle strobe, sample is new
//   phase_wrap   out  1            with sample_valid: accumulator wrapped on that request
//
// The quarter-wave table holds round(127*sin(pi/2*(k+0.5)/64)) for k = 0..63,
// i.e. it is tabulated for LUT_ADDR = 6 and DATA_WIDTH = 8. Other values of
// those two parameters need the table regenerated; PHASE_WIDTH is free
// (>= LUT_ADDR+2).
// -----------------------------------------------------------------------------
module sine_sample_gen #(
  parameter int PHASE_WIDTH = 16,
  parameter int LUT_ADDR    = 6,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk_100,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   sample_req,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic                   phase_wrap
);

  localparam int N = 1 << LUT_ADDR;

  // Offset-binary zero: the value at reset and the fold pivot.
  localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  // NOTE: the table is a constant ROM, so it has no reset and no write port;
  // only the pipeline registers below are reset.
  localparam int unsigned LUT_Q [N] = '{
      2,   5,   8,  11,  14,  17,  20,  23,
     26,  29,  32,  35,  38,  41,  44,  47,
     50,  53,  56,  58,  61,  64,  67,  69,
     72,  74,  77,  79,  82,  84,  86,  89,
     91,  93,  95,  97,  99, 101, 103, 105,
    106, 108, 110, 111, 113, 114, 115, 117,
    118, 119, 120, 121, 122, 123, 124, 124,
    125, 125, 126, 126, 127, 127, 127, 127
  };

  // ---------------------------------------------------------------------------
  // Stage 0: accumulator and request capture
  // ---------------------------------------------------------------------------
  logic                   accept;
  logic [PHASE_WIDTH:0]   acc_sum;     // extra MSB is the wrap carry
  logic [PHASE_WIDTH-1:0] acc;
  logic [LUT_ADDR+1:0]    phi_top_s0;  // only quadrant + index bits are kept
  logic                   wrap_s0;
  logic                   vld_s0;

  assign accept  = sample_req & en;
  assign acc_sum = {1'b0, acc} + {1'b0, fcw};

  // NOTE: every clocked register is assigned with <= so all stages read the
  // values from before the edge; blocking = here would collapse the pipeline.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      phi_top_s0 <= '0;
      wrap_s0    <= 1'b0;
      vld_s0     <= 1'b0;
    end else begin
      vld_s0 <= accept;
      if (accept) begin
        // Phase captured is the pre-increment value; the carry belongs to
        // this request.
        phi_top_s0 <= acc[PHASE_WIDTH-1 -: LUT_ADDR+2];
        acc        <= acc_sum[PHASE_WIDTH-1:0];
        wrap_s0    <= acc_sum[PHASE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: quadrant / index split
  // ---------------------------------------------------------------------------
  logic [1:0]          quad_s1;
  logic [LUT_ADDR-1:0] idx_s1;
  logic                wrap_s1;
  logic                vld_s1;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      quad_s1 <= '0;
      idx_s1  <= '0;
      wrap_s1 <= 1'b0;
      vld_s1  <= 1'b0;
    end else begin
      vld_s1 <= vld_s0;
      if (vld_s0) begin
        quad_s1 <= phi_top_s0[LUT_ADDR+1 -: 2];
        idx_s1  <= phi_top_s0[LUT_ADDR-1:0];
        wrap_s1 <= wrap_s0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: table read and quadrant fold
  // ---------------------------------------------------------------------------
  logic [LUT_ADDR-1:0]   lut_addr;
  logic [DATA_WIDTH-1:0] lut_val;
  logic [DATA_WIDTH-1:0] fold_val;

  // NOTE: each always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    lut_addr = idx_s1;
    lut_val  = '0;
    fold_val = MID;
    // Odd quadrants run the table backwards; N-1-i is the bitwise inverse.
    if (quad_s1[0]) lut_addr = ~idx_s1;
    lut_val = DATA_WIDTH'(LUT_Q[lut_addr]);
    // Lower half-cycle mirrors about the midscale so x and x+half sum to 2^D-1.
    if (quad_s1[1]) fold_val = MID - DATA_WIDTH'(1) - lut_val;
    else            fold_val = MID + lut_val;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= MID;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      sample_valid <= vld_s1;
      phase_wrap   <= vld_s1 & wrap_s1;
      if (vld_s1) sample <= fold_val;
    end
  end

endmodule

// File: tb/tb_sine_sample_gen.sv
// -----------------------------------------------------------------------------
// tb_sine_sample_gen
//
// Directed and randomized bench for sine_sample_gen. A reference model turns
// each accepted request into an expected (due edge, sample, wrap) entry using
// real-valued sine and integer phase arithmetic; every cycle the DUT outputs
// are compared on the falling edge against that schedule.
// -----------------------------------------------------------------------------
module tb_sine_sample_gen;

  localparam int P  = 16;
  localparam int LA = 6;
  localparam int D  = 8;

  localparam int PHASE_MOD = 1 << P;
  localparam int MIDSCALE  = 1 << (D - 1);

  logic         clk_100 = 1'b0;
  logic         rst_n;
  logic         en;
  logic [P-1:0] fcw;
  logic         sample_req;
  logic [D-1:0] sample;
  logic         sample_valid;
  logic         phase_wrap;

  always #5 clk_100 = ~clk_100;

  sine_sample_gen #(
    .PHASE_WIDTH (P),
    .LUT_ADDR    (LA),
    .DATA_WIDTH  (D)
  ) dut (
    .clk_100      (clk_100),
    .rst_n        (rst_n),
    .en           (en),
    .fcw          (fcw),
    .sample_req   (sample_req),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap)
  );

  typedef struct {
    int due;
    int smp;
    bit wrap;
  } exp_t;

  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   edge_cnt      = 0;
  int   model_phase   = 0;
  int   last_sample   = MIDSCALE;
  exp_t pend_q[$];
  int   obs_q[$];
  int   wrap_cnt      = 0;
  int   wrap_pos      = 0;
  int   held_phase    = 0;

  // Expected sample for a phase, straight from the sine definition.
  function automatic int ref_sample(input int phase);
    int  quarter;
    int  step;
    int  q;
    int  i;
    int  a;
    int  mag;
    real ang;
    quarter = PHASE_MOD / 4;
    step    = quarter / (1 << LA);
    q       = phase / quarter;
    i       = (phase % quarter) / step;
    a       = (q % 2 == 1) ? ((1 << LA) - 1 - i) : i;
    ang     = 3.14159265358979 / 2.0 * (real'(a) + 0.5) / real'(1 << LA);
    mag     = $rtoi(real'(MIDSCALE - 1) * $sin(ang) + 0.5);
    return (q < 2) ? (MIDSCALE + mag) : (MIDSCALE - 1 - mag);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_vectors++;
    assert (obs === expd) else begin
      n_miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expd);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    model_phase = 0;
    last_sample = MIDSCALE;
  endtask

  // One clock: model acceptance at the rising edge, compare on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk_100);
    edge_cnt++;
    if (rst_n === 1'b1 && en === 1'b1 && sample_req === 1'b1) begin
      e.due  = edge_cnt + 2;
      e.smp  = ref_sample(model_phase);
      e.wrap = (model_phase + int'(fcw)) >= PHASE_MOD;
      pend_q.push_back(e);
      model_phase = (model_phase + int'(fcw)) % PHASE_MOD;
    end
    @(negedge clk_100);
    if (pend_q.size() > 0 && pend_q[0].due == edge_cnt) begin
      e = pend_q.pop_front();
      check("valid_strobe", 32'(sample_valid), 1);
      check("sample_value", 32'(sample), e.smp);
      check("wrap_strobe", 32'(phase_wrap), 32'(e.wrap));
      last_sample = e.smp;
      if (sample_valid === 1'b1) begin
        obs_q.push_back(int'(sample));
        if (phase_wrap === 1'b1) begin
          wrap_cnt++;
          wrap_pos = obs_q.size();
        end
      end
    end else begin
      check("valid_idle", 32'(sample_valid), 0);
      check("sample_hold", 32'(sample), last_sample);
      check("wrap_idle", 32'(phase_wrap), 0);
    end
  endtask

  task automatic request_then_idle(input int idle);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (idle) tick();
  endtask

  initial begin
    // ---- Reset with random request/enable activity --------------------------
    rst_n      = 1'b0;
    en         = 1'b0;
    sample_req = 1'b0;
    fcw        = '0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      en         = 1'($urandom);
      sample_req = 1'($urandom);
      fcw        = 16'($urandom);
      tick();
    end
    en         = 1'b0;
    sample_req = 1'b0;
    rst_n      = 1'b1;
    repeat (5) tick();
    check("reset_sample", 32'(sample), 128);
    check("reset_valid", 32'(sample_valid), 0);

    // ---- fcw=1024, 64 requests one PWM period (300 cycles) apart -----------
    obs_q.delete();
    wrap_cnt = 0;
    wrap_pos = 0;
    en       = 1'b1;
    fcw      = 16'd1024;
    for (int k = 0; k < 64; k++) request_then_idle(299);
    check("period_count", obs_q.size(), 64);
    check("period_s1", obs_q[0], 130);
    check("period_s17", obs_q[16], 255);
    check("period_s33", obs_q[32], 125);
    check("period_s49", obs_q[48], 0);
    check("period_wrap_cnt", wrap_cnt, 1);
    check("period_wrap_pos", wrap_pos, 64);

    // ---- Back-to-back requests, fcw=4096 -----------------------------------
    obs_q.delete();
    fcw        = 16'd4096;
    sample_req = 1'b1;
    repeat (10) tick();
    sample_req = 1'b0;
    repeat (4) tick();
    check("b2b_count", obs_q.size(), 10);
    check("b2b_sym_0", obs_q[0] + obs_q[8], 255);
    check("b2b_sym_1", obs_q[1] + obs_q[9], 255);

    // ---- Enable low for 30 us while requests continue ----------------------
    obs_q.delete();
    fcw = 16'd256;
    repeat (3) request_then_idle(20);
    sample_req = 1'b1;
    tick();                 // accepted, en still high
    en = 1'b0;              // coincident request below is not accepted
    tick();
    sample_req = 1'b0;
    tick();                 // in-flight sample lands here
    check("en_inflight_count", obs_q.size(), 4);
    obs_q.delete();
    held_phase = model_phase;
    for (int k = 0; k < 10; k++) request_then_idle(299);
    check("en_low_count", obs_q.size(), 0);
    en = 1'b1;
    repeat (3) request_then_idle(20);
    check("en_resume_count", obs_q.size(), 3);
    check("en_resume_first", obs_q[0], ref_sample(held_phase));
    check("en_resume_second", obs_q[1], ref_sample((held_phase + 256) % PHASE_MOD));

    // ---- Reset one cycle after a request -----------------------------------
    fcw        = 16'd1024;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    repeat (3) tick();
    check("midreset_sample", 32'(sample), 128);
    rst_n = 1'b1;
    repeat (3) tick();
    check("midreset_valid", 32'(sample_valid), 0);

    // ---- fcw=0: five identical samples, no wrap ----------------------------
    obs_q.delete();
    wrap_cnt = 0;
    fcw      = 16'd0;
    repeat (5) request_then_idle(3);
    check("fcw0_count", obs_q.size(), 5);
    for (int k = 0; k < 5; k++) check("fcw0_sample", obs_q[k], 130);
    check("fcw0_wrap_cnt", wrap_cnt, 0);

    // ---- Random requests, enables and frequency words ----------------------
    for (int k = 0; k < 400; k++) begin
      en         = 1'($urandom_range(0, 3) != 0);
      sample_req = 1'($urandom);
      if ($urandom_range(0, 7) == 0) fcw = 16'($urandom);
      tick();
    end
    sample_req = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
